// File: rtl/sp_ram_req_ctrl.sv
// ---------------------------------------------------------------------------
// sp_ram_req_ctrl
//
// Initiator-side controller for the single-port block-RAM model. A client
// (for example a CAM lookup engine) presents read/write requests on a
// valid/ready stream; this block drives the RAM pin protocol in the same cycle
// the request is accepted, follows the RAM's fixed read latency with a small
// shift register, and hands read data back through a response FIFO that has
// its own valid/ready backpressure.
//
// Handshake semantics (both streams): a beat transfers on a rising clk edge
// where valid && ready are both high. req_ready does not depend on req_valid
// or req_wr. rsp_valid does not depend on rsp_ready. Once rsp_valid is high it
// stays high, with stable rsp_rdata, until the beat is consumed.
//
// Admission is credit based. Every read (and every write, when write acks are
// enabled) holds one credit from acceptance until its response leaves the
// FIFO. Because there are only RSP_DEPTH credits, the FIFO can never overflow.
//
// Optional feature macro: SP_RAM_CTRL_WR_ACK_EN
//   When it is defined, every accepted write also travels down the read
//   pipeline and returns a response with rsp_rdata = 0. The extra port rsp_wr
//   marks those responses. When it is undefined, writes produce no response
//   and rsp_wr does not exist.
//
// Parameters:
//   ADDR_WIDTH  RAM address width
//   DATA_WIDTH  RAM data width
//   MASK_WIDTH  write-mask width (passed through unchanged)
//   RD_LATENCY  RAM read latency, 1 (low latency) or 2 (output registered)
//   RSP_DEPTH   response FIFO depth, power of 2, >= RD_LATENCY+2
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   req_valid/ready   request handshake
//   req_wr            1 = write, 0 = read
//   req_addr/wdata/mask  request payload
//   rsp_valid/ready   response handshake
//   rsp_rdata         read data at the FIFO head
//   rsp_wr            (write-ack build only) response is a write ack
//   ram_chip_en, ram_wr_en, ram_addr, ram_wdata, ram_mask  RAM request pins
//   ram_rst           RAM reset, equal to rst
//   ram_reg_en        RAM output-register enable
//   ram_rdata         RAM read data
// ---------------------------------------------------------------------------
module sp_ram_req_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 72,
  parameter int MASK_WIDTH = 72,
  parameter int RD_LATENCY = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // request stream
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [MASK_WIDTH-1:0] req_mask,
  // response stream
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
`ifdef SP_RAM_CTRL_WR_ACK_EN
  output logic                  rsp_wr,
`endif
  // RAM pins
  output logic                  ram_chip_en,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [MASK_WIDTH-1:0] ram_mask,
  output logic                  ram_rst,
  output logic                  ram_reg_en,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  // Pointer width, occupancy width (must hold RSP_DEPTH itself) and the
  // width of the credit sum (occupancy plus up to RD_LATENCY in flight).
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam int UW = CW + 1;

  // ---------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("sp_ram_req_ctrl: RD_LATENCY must be 1 or 2");
  end
  if (RSP_DEPTH < RD_LATENCY + 2) begin : g_bad_depth
    $error("sp_ram_req_ctrl: RSP_DEPTH must be >= RD_LATENCY+2");
  end
  if ((RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_pow2
    $error("sp_ram_req_ctrl: RSP_DEPTH must be a power of 2");
  end

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  logic                  w_acc;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic [UW-1:0]         w_pipe_cnt;
  logic [UW-1:0]         w_used;

  // r_rd_pipe[i] is set when a response-producing request was accepted
  // i+1 cycles ago; the last stage lines up with valid ram_rdata.
  logic [RD_LATENCY-1:0] r_rd_pipe;

  logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

`ifdef SP_RAM_CTRL_WR_ACK_EN
  // Parallel to r_rd_pipe: marks in-flight entries that are write acks.
  logic [RD_LATENCY-1:0] r_wr_pipe;
  logic                  r_wr_mem [RSP_DEPTH];
`endif

  // ---------------------------------------------------------------------
  // Credits and request acceptance
  // ---------------------------------------------------------------------
  // Everything that will eventually occupy a FIFO slot is counted: what is
  // already stored plus what is still travelling through the RAM. Only
  // registered state is used, so a pop this cycle frees its credit next cycle.
  always_comb begin
    w_pipe_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_pipe_cnt = w_pipe_cnt + UW'(r_rd_pipe[i]);
    end
  end

  assign w_used    = UW'(r_count) + w_pipe_cnt;
  assign req_ready = !rst && (w_used < UW'(RSP_DEPTH));
  assign w_acc     = req_valid && req_ready;

  // ---------------------------------------------------------------------
  // RAM pin drive (same cycle as acceptance)
  // ---------------------------------------------------------------------
  assign ram_chip_en = w_acc;
  assign ram_wr_en   = w_acc && req_wr;
  assign ram_addr    = req_addr;
  assign ram_wdata   = req_wdata;
  assign ram_mask    = req_mask;
  assign ram_rst     = rst;

  // With an output-registered RAM the second stage must capture exactly one
  // cycle after the access, which is when r_rd_pipe[0] is set.
  if (RD_LATENCY == 2) begin : g_reg_en_pipe
    assign ram_reg_en = r_rd_pipe[0];
  end else begin : g_reg_en_tied
    assign ram_reg_en = 1'b1;
  end

  // ---------------------------------------------------------------------
  // Read tracking pipeline
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_pipe <= '0;
    end else begin
`ifdef SP_RAM_CTRL_WR_ACK_EN
      r_rd_pipe[0] <= w_acc;
`else
      r_rd_pipe[0] <= w_acc && !req_wr;
`endif
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_rd_pipe[i] <= r_rd_pipe[i-1];
      end
    end
  end

`ifdef SP_RAM_CTRL_WR_ACK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_pipe <= '0;
    end else begin
      r_wr_pipe[0] <= w_acc && req_wr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_wr_pipe[i] <= r_wr_pipe[i-1];
      end
    end
  end

  // Write acks carry zero data rather than whatever the RAM drives.
  assign w_push_data = r_wr_pipe[RD_LATENCY-1] ? '0 : ram_rdata;
`else
  assign w_push_data = ram_rdata;
`endif

  // ---------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------
  assign w_push    = r_rd_pipe[RD_LATENCY-1];
  assign rsp_valid = !rst && (r_count != '0);
  assign w_pop     = rsp_valid && rsp_ready;
  assign rsp_rdata = r_mem[r_rptr];

  // Pointers are exactly PW bits wide, so they wrap modulo RSP_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset; stale entries are unreachable once the pointers
  // and count are cleared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_data;
    end
  end

`ifdef SP_RAM_CTRL_WR_ACK_EN
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wr_mem[r_wptr] <= r_wr_pipe[RD_LATENCY-1];
    end
  end

  assign rsp_wr = r_wr_mem[r_rptr];
`endif

  // Credits should make a push into a full FIFO impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_count == CW'(RSP_DEPTH))));

endmodule

// File: tb/tb_sp_ram_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sp_ram_req_ctrl
//
// Two instances: dut A (RD_LATENCY=1, RSP_DEPTH=4) and dut B (RD_LATENCY=2,
// RSP_DEPTH=4), each attached to a small behavioural RAM model. A table of
// request vectors checks the combinational pin drive, followed by hand-written
// sequences for latency, backpressure, credit return, FIFO wrap, reset during
// flight and (write-ack build) write acknowledgements. Each instance has a
// response monitor that compares every consumed response against an expected
// queue filled when a request is accepted.
// ---------------------------------------------------------------------------
module tb_sp_ram_req_ctrl;

  localparam int AW = 9;
  localparam int DW = 72;
  localparam int MW = 72;
`ifdef SP_RAM_CTRL_WR_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- dut A signals ----------------
  logic          a_rst, a_req_valid, a_req_ready, a_req_wr;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_wdata;
  logic [MW-1:0] a_req_mask;
  logic          a_rsp_valid, a_rsp_ready;
  logic [DW-1:0] a_rsp_rdata;
  logic          a_ram_chip_en, a_ram_wr_en, a_ram_rst, a_ram_reg_en;
  logic [AW-1:0] a_ram_addr;
  logic [DW-1:0] a_ram_wdata;
  logic [MW-1:0] a_ram_mask;
  logic [DW-1:0] a_ram_rdata = '0;
  logic          a_got_wr;

  // ---------------- dut B signals ----------------
  logic          b_rst, b_req_valid, b_req_ready, b_req_wr;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_wdata;
  logic [MW-1:0] b_req_mask;
  logic          b_rsp_valid, b_rsp_ready;
  logic [DW-1:0] b_rsp_rdata;
  logic          b_ram_chip_en, b_ram_wr_en, b_ram_rst, b_ram_reg_en;
  logic [AW-1:0] b_ram_addr;
  logic [DW-1:0] b_ram_wdata;
  logic [MW-1:0] b_ram_mask;
  logic [DW-1:0] b_ram_rdata = '0;
  logic [DW-1:0] b_q1 = '0;
  logic          b_got_wr;

`ifdef SP_RAM_CTRL_WR_ACK_EN
  logic a_rsp_wr, b_rsp_wr;
  assign a_got_wr = a_rsp_wr;
  assign b_got_wr = b_rsp_wr;
`else
  assign a_got_wr = 1'b0;
  assign b_got_wr = 1'b0;
`endif

  sp_ram_req_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
    .RD_LATENCY(1), .RSP_DEPTH(4)
  ) dut_a (
    .clk(clk), .rst(a_rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wr(a_req_wr),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_mask(a_req_mask),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
`ifdef SP_RAM_CTRL_WR_ACK_EN
    .rsp_wr(a_rsp_wr),
`endif
    .ram_chip_en(a_ram_chip_en), .ram_wr_en(a_ram_wr_en), .ram_addr(a_ram_addr),
    .ram_wdata(a_ram_wdata), .ram_mask(a_ram_mask), .ram_rst(a_ram_rst),
    .ram_reg_en(a_ram_reg_en), .ram_rdata(a_ram_rdata)
  );

  sp_ram_req_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
    .RD_LATENCY(2), .RSP_DEPTH(4)
  ) dut_b (
    .clk(clk), .rst(b_rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(b_req_wr),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_mask(b_req_mask),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
`ifdef SP_RAM_CTRL_WR_ACK_EN
    .rsp_wr(b_rsp_wr),
`endif
    .ram_chip_en(b_ram_chip_en), .ram_wr_en(b_ram_wr_en), .ram_addr(b_ram_addr),
    .ram_wdata(b_ram_wdata), .ram_mask(b_ram_mask), .ram_rst(b_ram_rst),
    .ram_reg_en(b_ram_reg_en), .ram_rdata(b_ram_rdata)
  );

  // ---------------- RAM models ----------------
  logic [DW-1:0] a_mem [512];
  logic [DW-1:0] b_mem [512];
  logic [DW-1:0] ref_mem [512];

  // Latency 1: data for an access at edge e is on rdata until edge e+1.
  always @(posedge clk) begin
    if (a_ram_chip_en) begin
      if (a_ram_wr_en)
        a_mem[a_ram_addr] <= (a_mem[a_ram_addr] & ~a_ram_mask) | (a_ram_wdata & a_ram_mask);
      else
        a_ram_rdata <= a_mem[a_ram_addr];
    end
  end

  // Latency 2: array read into b_q1, then the output register loads on reg_en.
  always @(posedge clk) begin
    if (b_ram_chip_en && !b_ram_wr_en) b_q1 <= b_mem[b_ram_addr];
    if (b_ram_reg_en) b_ram_rdata <= b_q1;
  end

  // ---------------- scoreboards ----------------
  logic [DW:0] a_exp_q[$];
  logic [DW:0] b_exp_q[$];
  logic [DW:0] a_e, b_e;
  int b_first_cyc = -1;
  int b_got = 0;

  always @(negedge clk) begin
    if (a_rsp_valid && a_rsp_ready) begin
      total++;
      if (a_exp_q.size() == 0) begin
        bad++;
        $display("FAIL a_rsp_unexpected: got wr=%b rdata=%h, none expected", a_got_wr, a_rsp_rdata);
      end else begin
        a_e = a_exp_q.pop_front();
        if ({a_got_wr, a_rsp_rdata} !== a_e) begin
          bad++;
          $display("FAIL a_rsp_data: got wr=%b rdata=%h, expected wr=%b rdata=%h",
                   a_got_wr, a_rsp_rdata, a_e[DW], a_e[DW-1:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_rsp_valid && b_rsp_ready) begin
      total++;
      if (b_first_cyc < 0) b_first_cyc = cyc;
      b_got++;
      if (b_exp_q.size() == 0) begin
        bad++;
        $display("FAIL b_rsp_unexpected: got rdata=%h, none expected", b_rsp_rdata);
      end else begin
        b_e = b_exp_q.pop_front();
        if ({b_got_wr, b_rsp_rdata} !== b_e) begin
          bad++;
          $display("FAIL b_rsp_data: got wr=%b rdata=%h, expected wr=%b rdata=%h",
                   b_got_wr, b_rsp_rdata, b_e[DW], b_e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [DW:0] got, input logic [DW:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Records what an accepted request on dut A must return.
  task automatic a_push_exp(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    if (wr) begin
      ref_mem[addr] = d;
      if (ACK) a_exp_q.push_back({1'b1, {DW{1'b0}}});
    end else begin
      a_exp_q.push_back({1'b0, ref_mem[addr]});
    end
  endtask

  // One request on dut A, waiting (bounded) for req_ready.
  task automatic a_send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    int n;
    n = 0;
    a_req_valid = 1'b1; a_req_wr = wr; a_req_addr = addr; a_req_wdata = d;
    @(negedge clk);
    while (!a_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("a_send_ready", a_req_ready, 1);
    if (a_req_ready) a_push_exp(wr, addr, d);
    else a_req_valid = 1'b0;
    tick();
    a_req_valid = 1'b0;
  endtask

  // Continuous reads on dut A; optionally toggles rsp_ready in a fixed pattern.
  logic [AW-1:0] a_next = 9'h040;
  task automatic a_stream(input int cycles, input int want, input bit pat, output int n);
    n = 0;
    for (int k = 0; k < cycles && n < want; k++) begin
      if (pat) a_rsp_ready = (k % 3 != 2);
      a_req_valid = 1'b1; a_req_wr = 1'b0; a_req_addr = a_next;
      @(negedge clk);
      if (a_req_ready) begin
        a_push_exp(1'b0, a_next, '0);
        n++;
        a_next = 9'h040 | ((a_next + 9'd1) & 9'h00F);
      end
      tick();
    end
    a_req_valid = 1'b0;
  endtask

  task automatic a_drain(input string name);
    int n;
    n = 0;
    a_rsp_ready = 1'b1;
    while (a_exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check(name, a_exp_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          valid;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_chip;
    logic          exp_wen;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vt[12];

  // ---------------- main test ----------------
  initial begin
    int n;
    int t0;

    for (int i = 0; i < 512; i++) begin
      a_mem[i]   = 72'h5C0000000000000000 | 72'(i);
      ref_mem[i] = 72'h5C0000000000000000 | 72'(i);
      b_mem[i]   = 72'(i * 3);
    end

    vt[0]  = '{1'b0, 1'b0, 9'h0AB, 72'h77,                 1'b0, 1'b0, 72'h0};
    vt[1]  = '{1'b1, 1'b1, 9'h005, 72'hA5A5,               1'b1, 1'b1, 72'h0};
    vt[2]  = '{1'b1, 1'b0, 9'h005, 72'h0,                  1'b1, 1'b0, 72'hA5A5};
    vt[3]  = '{1'b1, 1'b1, 9'h1FF, 72'h800000000000000001, 1'b1, 1'b1, 72'h0};
    vt[4]  = '{1'b1, 1'b1, 9'h000, 72'h123456789ABCDEF012, 1'b1, 1'b1, 72'h0};
    vt[5]  = '{1'b1, 1'b0, 9'h1FF, 72'h0,                  1'b1, 1'b0, 72'h800000000000000001};
    vt[6]  = '{1'b1, 1'b0, 9'h000, 72'h0,                  1'b1, 1'b0, 72'h123456789ABCDEF012};
    vt[7]  = '{1'b0, 1'b1, 9'h005, 72'hFFFF,               1'b0, 1'b0, 72'h0};
    vt[8]  = '{1'b1, 1'b0, 9'h005, 72'h0,                  1'b1, 1'b0, 72'hA5A5};
    vt[9]  = '{1'b1, 1'b1, 9'h005, 72'h5A5A,               1'b1, 1'b1, 72'h0};
    vt[10] = '{1'b1, 1'b0, 9'h005, 72'h0,                  1'b1, 1'b0, 72'h5A5A};
    vt[11] = '{1'b1, 1'b0, 9'h0AB, 72'h0,                  1'b1, 1'b0, 72'h5C00000000000000AB};

    // Reset state
    a_rst = 1'b1; b_rst = 1'b1;
    a_req_valid = 1'b0; a_req_wr = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_mask = '1;
    b_req_valid = 1'b0; b_req_wr = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_mask = '1;
    a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check("rst_a_ctl", {a_req_ready, a_rsp_valid, a_ram_chip_en, a_ram_rst, a_ram_reg_en}, 5'b00011);
    check("rst_b_ctl", {b_req_ready, b_rsp_valid, b_ram_reg_en, b_ram_rst}, 4'b0001);
    check("rst_a_mask", a_ram_mask, a_req_mask);
    tick();
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {a_req_ready, b_req_ready, a_ram_rst, b_ram_rst}, 4'b1100);
    tick();

    // Table: pin drive and back-to-back write/read ordering
    for (int i = 0; i < 12; i++) begin
      a_req_valid = vt[i].valid; a_req_wr = vt[i].wr;
      a_req_addr  = vt[i].addr;  a_req_wdata = vt[i].wdata;
      @(negedge clk);
      check($sformatf("vec%0d_ctl", i), {a_ram_chip_en, a_ram_wr_en, a_req_ready, a_ram_addr},
            {vt[i].exp_chip, vt[i].exp_wen, 1'b1, vt[i].addr});
      check($sformatf("vec%0d_wdata", i), a_ram_wdata, vt[i].wdata);
      if (a_req_valid && a_req_ready) begin
        if (vt[i].wr) a_push_exp(1'b1, vt[i].addr, vt[i].wdata);
        else a_exp_q.push_back({1'b0, vt[i].exp_rd});
      end
      tick();
    end
    a_req_valid = 1'b0;
    a_drain("table_drain");

    // Read latency with an empty FIFO: valid in T+2
    a_send(1'b1, 9'h005, 72'hA5A5);
    repeat (3) tick();
    a_send(1'b0, 9'h005, '0);
    @(negedge clk);
    check("lat_t1_valid", a_rsp_valid, 0);
    tick();
    @(negedge clk);
    check("lat_t2_valid", a_rsp_valid, 1);
    check("lat_t2_data", a_rsp_rdata, 72'hA5A5);
    tick();
    a_drain("lat_drain");

    // Backpressure: exactly 4 acceptances, credit returns one cycle after pop
    a_rsp_ready = 1'b0;
    a_stream(10, 100, 1'b0, n);
    check("bp_accepts", n, 4);
    @(negedge clk);
    check("bp_ready_low", a_req_ready, 0);
    tick();
    a_rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_cycle_ready", a_req_ready, 0);
    tick();
    @(negedge clk);
    check("bp_after_pop_ready", a_req_ready, 1);
    tick();
    a_drain("bp_drain");

    // Simultaneous push and pop at 3/4 full keeps occupancy at 3
    a_rsp_ready = 1'b0;
    a_stream(3, 3, 1'b0, n);
    check("q3_fill", n, 3);
    repeat (3) tick();
    a_stream(1, 1, 1'b0, n);
    check("q3_fourth", n, 1);
    a_rsp_ready = 1'b1;
    @(negedge clk);
    check("q3_full_ready", a_req_ready, 0);
    tick();
    a_rsp_ready = 1'b0;
    @(negedge clk);
    check("q3_cnt3_ready", a_req_ready, 1);
    tick();
    a_stream(6, 100, 1'b0, n);
    check("q3_one_more", n, 1);
    // 20 transactions across pointer wrap with irregular consumption
    a_stream(200, 20, 1'b1, n);
    check("wrap_accepts", n, 20);
    a_drain("wrap_drain");

    // Reset while two reads are in flight
    a_send(1'b0, 9'h030, '0);
    a_send(1'b0, 9'h031, '0);
    a_rst = 1'b1;
    a_exp_q.delete();
    @(negedge clk);
    check("rstf_during", {a_rsp_valid, a_req_ready}, 2'b00);
    tick();
    a_rst = 1'b0;
    @(negedge clk);
    check("rstf_after_valid", a_rsp_valid, 0);
    repeat (6) tick();
    a_send(1'b0, 9'h005, '0);
    a_drain("rstf_drain");

`ifdef SP_RAM_CTRL_WR_ACK_EN
    // Write ack followed by read of the written data
    a_send(1'b1, 9'h010, 72'hDEADBEEF);
    a_send(1'b0, 9'h010, '0);
    a_drain("ack_drain");
`endif

    // dut B: 16 back-to-back reads with latency 2
    b_first_cyc = -1;
    b_got = 0;
    t0 = -1;
    for (int i = 0; i < 16; i++) begin
      b_req_valid = 1'b1; b_req_addr = AW'(i);
      @(negedge clk);
      check($sformatf("b_stream_ready%0d", i), b_req_ready, 1);
      if (b_req_ready) begin
        b_exp_q.push_back({1'b0, 72'(i * 3)});
        if (t0 < 0) t0 = cyc;
      end
      tick();
    end
    b_req_valid = 1'b0;
    n = 0;
    while ((b_exp_q.size() != 0 || b_got < 16) && n < 50) begin
      tick();
      n++;
    end
    check("b_count", b_got, 16);
    check("b_left", b_exp_q.size(), 0);
    check("b_first_latency", b_first_cyc - t0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sp_ram_req_ctrl.md
Name: sp_ram_req_ctrl

Overview:
- Initiator-side controller for the single-port block-RAM model. It converts a valid/ready request stream (read/write) from a client, such as a CAM lookup engine, into the RAM's chip_en/wr_en/addr/wdata/mask pin protocol.
- Tracks the RAM's fixed read latency (1 = low-latency, 2 = output-registered) and returns read data through a response FIFO with valid/ready backpressure.
- Credit-based admission guarantees the FIFO never overflows.

Parameters:
- ADDR_WIDTH, 9, RAM address width.
- DATA_WIDTH, 72, RAM data width.
- MASK_WIDTH, 72, write-mask width; passed through unchanged.
- RD_LATENCY, 1, RAM read latency in cycles; legal values 1 and 2 (2 matches HIGH_PERFORMANCE).
- RSP_DEPTH, 4, response FIFO depth; power of 2, must be >= RD_LATENCY+2 (elaboration error otherwise).

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; synchronous, active-high.
- req_valid, input, 1, request valid.
- req_ready, output, 1, request accepted when req_valid && req_ready.
- req_wr, input, 1, 1 = write, 0 = read.
- req_addr, input, ADDR_WIDTH, request address.
- req_wdata, input, DATA_WIDTH, write data.
- req_mask, input, MASK_WIDTH, write mask.
- rsp_valid, output, 1, response valid.
- rsp_ready, input, 1, response consumed when rsp_valid && rsp_ready.
- rsp_rdata, output, DATA_WIDTH, read data.
- ram_chip_en, output, 1, to RAM chip_en.
- ram_wr_en, output, 1, to RAM wr_en.
- ram_addr, output, ADDR_WIDTH, to RAM addr.
- ram_wdata, output, DATA_WIDTH, to RAM wdata.
- ram_mask, output, MASK_WIDTH, to RAM mask.
- ram_rst, output, 1, to RAM rst; equals rst.
- ram_reg_en, output, 1, to RAM reg_en.
- ram_rdata, input, DATA_WIDTH, from RAM rdata.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All registered state clears.
  - rsp_valid=0, req_ready=0 while rst is high.
  - Read pipeline, FIFO pointers and in-flight count all go to 0.
  - Requests in flight at reset are discarded; there is no partial response.
- Accept: acc = req_valid && req_ready.
- RAM pin drive (combinational, same cycle as acceptance):
  - ram_chip_en = acc.
  - ram_wr_en = acc && req_wr.
  - ram_addr = req_addr, ram_wdata = req_wdata, ram_mask = req_mask (pass-through).
- Read tracking:
  - rd_pipe is a RD_LATENCY-deep shift register; rd_pipe[0] <= acc && !req_wr.
  - When rd_pipe[RD_LATENCY-1]=1, ram_rdata is valid that cycle and is pushed into the FIFO at the next edge.
  - ram_reg_en = rd_pipe[0] when RD_LATENCY=2; tied 1 when RD_LATENCY=1.
- Latency:
  - Read accepted in cycle T gives rsp_valid=1 with its data in cycle T+RD_LATENCY+1, if the FIFO is empty.
  - Responses are returned in strict acceptance order.
- Writes produce no response. Back-to-back write-then-read to the same address returns the written data, because RAM ordering is in-order.
- Credits:
  - used = fifo_count + popcount(rd_pipe), both from registered state.
  - req_ready = !rst && (used < RSP_DEPTH), independent of req_valid and req_wr.
  - A pop in the current cycle frees its credit only from the next cycle.
- Throughput: with rsp_ready held at 1, one request per cycle is sustained indefinitely.
- FIFO:
  - Simultaneous push and pop: count unchanged, data order preserved.
  - Pop when empty: impossible, since rsp_valid=0.
  - Push when full: prevented by credits; a simulation assertion flags any occurrence.
  - Read and write pointers wrap modulo RSP_DEPTH.
- rsp_rdata holds the FIFO head; its value is don't-care when rsp_valid=0.

Optional Feature:
- Macro: SP_RAM_CTRL_WR_ACK_EN.
- Defined:
  - Each accepted write also enters the read pipeline and pushes a response with rsp_rdata = 0.
  - Extra output port rsp_wr (1 bit) flags write acks.
  - Writes consume a credit like reads.
- Undefined: writes produce no response, and the rsp_wr port is absent.

Test Plan:
- RD_LATENCY=1: write addr 0x05 data 0xA5A5, then read addr 0x05 -> one response, rsp_rdata=0xA5A5, rsp_valid in cycle T+2 after the read is accepted.
- RD_LATENCY=2, RSP_DEPTH=4, rsp_ready=1: 16 back-to-back reads of addrs 0..15 preloaded with addr*3 -> req_ready stays 1 throughout; 16 responses 0,3,...,45 in order, first at T+3.
- rsp_ready=0, RD_LATENCY=1, RSP_DEPTH=4: issue reads continuously.
  - req_ready drops after exactly 4 acceptances.
  - Raise rsp_ready: all 4 drain in order, and req_ready returns 1 cycle after the first pop.
- Assert rst for 1 cycle while 2 reads are in flight -> rsp_valid=0 the following cycle, no stale responses ever appear, and a subsequent read of 0x05 returns correct data.
- Simultaneous push and pop with the FIFO at 3/4 full -> count stays 3, and no data is lost or reordered across pointer wrap after 20 transactions.
- With SP_RAM_CTRL_WR_ACK_EN: write addr 0x10 -> response with rsp_wr=1, rsp_rdata=0; a following read -> rsp_wr=0 with the written data.
